// File: rtl/sim_exit_ctrl.sv
// -----------------------------------------------------------------------------
// sim_exit_ctrl
//
// Memory-mapped exit reporter for the simulation harness. Firmware writes a
// return code to EXIT_VALUE and then commits it through EXIT_CTRL. After the
// commit the block holds a sticky exit_valid_o and a frozen exit_value_o for
// the top-level bench. A free-running cycle counter is also readable.
//
// Register map (word offset taken from addr_i[ADDR_W-1:2], higher bits alias):
//   0x0 EXIT_CTRL  W: bit0=1 commits exit    R: {31'b0, exit_valid_o}
//   0x4 EXIT_VALUE RW, byte-enabled; drives exit_value_o while running
//   0x8 CYCLE      RO, clocks since reset deassertion (wraps)
//   0xC WDT_LIMIT  RW, byte-enabled (present only with SIM_EXIT_WDT_EN)
//
// Optional feature macro: SIM_EXIT_WDT_EN
//   Defined   : watchdog forces exit with WDT_EXIT_CODE once CYCLE reaches a
//               non-zero WDT_LIMIT.
//   Undefined : no WDT_LIMIT register; offset 0xC reads 0, writes ignored.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   req_i        OBI request
//   we_i         OBI write enable
//   be_i[3:0]    OBI byte enables
//   addr_i[31:0] OBI byte address
//   wdata_i      OBI write data
//   gnt_o        OBI grant (always ready, equals req_i)
//   rvalid_o     OBI response valid, one cycle after each accept
//   rdata_o      OBI read data, zero unless a read response is presented
//   exit_valid_o sticky: program has finished
//   exit_value_o return code, 0 = success
// -----------------------------------------------------------------------------
module sim_exit_ctrl #(
    parameter int          ADDR_W           = 4,
    parameter logic [31:0] WDT_EXIT_CODE    = 32'hDEAD_0001,
    parameter logic [31:0] RESET_EXIT_VALUE = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_EXITED = 1'b1
    } state_e;

    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] IDX_CTRL  = WIDX_W'(0);
    localparam logic [WIDX_W-1:0] IDX_VALUE = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] IDX_CYCLE = WIDX_W'(2);
`ifdef SIM_EXIT_WDT_EN
    localparam logic [WIDX_W-1:0] IDX_WDT   = WIDX_W'(3);
`endif

    // Byte-lane merge used by every byte-enabled register.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    state_e      state_q;
    logic        exit_valid_q;
    logic [31:0] exit_value_q, exit_value_d;
    logic [31:0] cycle_q, cycle_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic              accept;
    logic              wr_en;
    logic              commit;
    logic              wdt_hit;
    logic [WIDX_W-1:0] widx;

    // Address bits outside the decoded word offset are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W], addr_i[1:0]};

    assign gnt_o  = req_i;
    assign accept = req_i;
    assign widx   = addr_i[ADDR_W-1:2];

    // Register writes only take effect while running; EXITED is terminal.
    assign wr_en  = accept && we_i && (state_q == ST_RUN);
    assign commit = wr_en && (widx == IDX_CTRL) && be_i[0] && wdata_i[0];

`ifdef SIM_EXIT_WDT_EN
    logic [31:0] wdt_limit_q, wdt_limit_d;

    assign wdt_hit = (wdt_limit_q != 32'h0) && (cycle_q >= wdt_limit_q) &&
                     (state_q == ST_RUN);

    always_comb begin
        wdt_limit_d = wdt_limit_q;
        if (wr_en && (widx == IDX_WDT)) wdt_limit_d = merge_be(wdt_limit_q, wdata_i, be_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wdt_limit_q <= 32'h0;
        else       wdt_limit_q <= wdt_limit_d;
    end
`else
    assign wdt_hit = 1'b0;
`endif

    assign cycle_d  = cycle_q + 32'd1;
    assign rvalid_d = accept;

    // Read mux: data is captured at acceptance and presented with rvalid.
    always_comb begin
        rdata_d = 32'h0;
        if (accept && !we_i) begin
            case (widx)
                IDX_CTRL:  rdata_d = {31'b0, exit_valid_q};
                IDX_VALUE: rdata_d = exit_value_q;
                IDX_CYCLE: rdata_d = cycle_q;
`ifdef SIM_EXIT_WDT_EN
                IDX_WDT:   rdata_d = wdt_limit_q;
`endif
                default:   rdata_d = 32'h0;
            endcase
        end
    end

    // A software commit keeps the programmed value; only a lone watchdog
    // expiry overwrites it with the watchdog code.
    always_comb begin
        exit_value_d = exit_value_q;
        if (wr_en && (widx == IDX_VALUE)) exit_value_d = merge_be(exit_value_q, wdata_i, be_i);
        if (wdt_hit && !commit)           exit_value_d = WDT_EXIT_CODE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            exit_valid_q <= 1'b0;
            exit_value_q <= RESET_EXIT_VALUE;
            cycle_q      <= 32'h0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            exit_value_q <= exit_value_d;
            cycle_q      <= cycle_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            case (state_q)
                ST_RUN: begin
                    if (commit || wdt_hit) begin
                        state_q      <= ST_EXITED;
                        exit_valid_q <= 1'b1;
                    end
                end
                ST_EXITED: begin
                    state_q      <= ST_EXITED;
                    exit_valid_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_RUN;
                    exit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_value_o = exit_value_q;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_exit_ctrl
//
// Self-checking bench for sim_exit_ctrl. A small behavioural model tracks the
// exit flag, the return code, the watchdog limit and the clock count since
// reset; every bus access and output is compared against it.
// -----------------------------------------------------------------------------
module tb_sim_exit_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exit_valid;
    logic [31:0] exit_value;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit          m_exited;
    logic [31:0] m_value;
    logic [31:0] m_limit;
    logic [31:0] tb_cyc;

    sim_exit_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .be_i         (be),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .exit_valid_o (exit_valid),
        .exit_value_o (exit_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks elapsed since reset deassertion.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 32'h0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (en[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_exited = 1'b0;
        m_value  = 32'h0;
        m_limit  = 32'h0;
    endtask

    // One bus access; checks grant, the response one cycle later and the
    // exit outputs against the model.
    task automatic xfer(input bit w, input logic [3:0] ben, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic [31:0] off;
        @(negedge clk);
        req = 1'b1; we = w; be = ben; addr = a; wdata = wd;
        #1;
        check_eq("gnt", {31'b0, gnt}, 32'h1);
        off = a & 32'hC;
        @(posedge clk);
        #1;
        exp_rd = 32'h0;
        if (!w) begin
            case (off)
                32'h0: exp_rd = {31'b0, m_exited};
                32'h4: exp_rd = m_value;
                32'h8: exp_rd = tb_cyc - 32'd1;
`ifdef SIM_EXIT_WDT_EN
                32'hC: exp_rd = m_limit;
`endif
                default: exp_rd = 32'h0;
            endcase
        end
        if (w && !m_exited) begin
            if (off == 32'h4) m_value = lanes(m_value, wd, ben);
            if (off == 32'h0 && ben[0] && wd[0]) m_exited = 1'b1;
`ifdef SIM_EXIT_WDT_EN
            if (off == 32'hC) m_limit = lanes(m_limit, wd, ben);
`endif
        end
        check_eq("rvalid", {31'b0, rvalid}, 32'h1);
        check_eq("rdata", rdata, exp_rd);
        check_eq("exit_valid", {31'b0, exit_valid}, {31'b0, m_exited});
        check_eq("exit_value", exit_value, m_value);
        rd = rdata;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_eq("idle_rvalid", {31'b0, rvalid}, 32'h0);
            check_eq("idle_rdata", rdata, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          sel;
        int          guard;

        rst = 1'b1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state and idle cycle count
        do_reset();
        #1;
        check_eq("rst_exit_valid", {31'b0, exit_valid}, 32'h0);
        check_eq("rst_exit_value", exit_value, 32'h0);
        check_eq("rst_rvalid", {31'b0, rvalid}, 32'h0);
        idle(10);
        check_eq("idle_exit_valid", {31'b0, exit_valid}, 32'h0);
        xfer(1'b0, 4'hF, 32'h8, 32'h0, rd);
        check_eq("cycle_window", {31'b0, (rd == 32'd10 || rd == 32'd11)}, 32'h1);

        // Software commit of 0x2A
        xfer(1'b1, 4'hF, 32'h4, 32'h0000_002A, rd);
        check_eq("pre_commit_valid", {31'b0, exit_valid}, 32'h0);
        xfer(1'b1, 4'hF, 32'h0, 32'h1, rd);
        check_eq("commit_valid", {31'b0, exit_valid}, 32'h1);
        check_eq("commit_value", exit_value, 32'h2A);

        // Writes after exit are ignored, responses continue back to back
        xfer(1'b1, 4'hF, 32'h4, 32'h5, rd);
        xfer(1'b0, 4'hF, 32'h4, 32'h0, rd);
        check_eq("frozen_read", rd, 32'h2A);
        xfer(1'b0, 4'hF, 32'h0, 32'h0, rd);
        xfer(1'b1, 4'hF, 32'h0, 32'h0, rd);
        idle(1);
        check_eq("frozen_value", exit_value, 32'h2A);

        // Byte-enabled write, alias read, non-committing control writes
        do_reset();
        xfer(1'b1, 4'b0010, 32'h4, 32'h0000_FF00, rd);
        check_eq("be_value", exit_value, 32'h0000_FF00);
        xfer(1'b0, 4'hF, 32'h20, 32'h0, rd);
        check_eq("alias_read", rd, 32'h0);
        xfer(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFE, rd);
        xfer(1'b1, 4'hE, 32'h0, 32'hFFFF_FFFF, rd);
        check_eq("no_commit", {31'b0, exit_valid}, 32'h0);
        xfer(1'b0, 4'hF, 32'hC, 32'h0, rd);

        // Asynchronous reset drops a pending response and clears the exit
        xfer(1'b1, 4'hF, 32'h0, 32'h1, rd);
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h4;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_eq("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rvalid", {31'b0, rvalid}, 32'h0);
        check_eq("async_rdata", rdata, 32'h0);
        check_eq("async_valid", {31'b0, exit_valid}, 32'h0);
        check_eq("async_value", exit_value, 32'h0);

        // Randomised accesses against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 59) do_reset();
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                default: a = $urandom;
            endcase
`ifdef SIM_EXIT_WDT_EN
            if ((a & 32'hC) == 32'hC) xfer(1'b0, 4'hF, a, 32'h0, rd);
            else
`endif
            xfer(1'($urandom_range(0, 1)), 4'($urandom), a,
                 ($urandom_range(0, 7) == 0) ? 32'h1 : ($urandom & 32'hFFFF_FFFE), rd);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

`ifdef SIM_EXIT_WDT_EN
        // Watchdog expiry with no commit
        do_reset();
        xfer(1'b1, 4'hF, 32'hC, 32'd100, rd);
        guard = 0;
        while (tb_cyc < 32'd110 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            check_eq("wdt_valid", {31'b0, exit_valid}, {31'b0, (tb_cyc >= 32'd101)});
        end
        check_eq("wdt_guard", {31'b0, (guard < 200)}, 32'h1);
        check_eq("wdt_value", exit_value, 32'hDEAD_0001);

        // Commit landing on the expiry cycle keeps the software value
        do_reset();
        xfer(1'b1, 4'hF, 32'h4, 32'h77, rd);
        xfer(1'b1, 4'hF, 32'hC, 32'd100, rd);
        guard = 0;
        while (tb_cyc < 32'd100 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("tie_guard", tb_cyc, 32'd100);
        xfer(1'b1, 4'hF, 32'h0, 32'h1, rd);
        idle(2);
        check_eq("tie_value", exit_value, 32'h77);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
